// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues word requests to instruction memory and buffers
// the returned words in a small FIFO that feeds decode.
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] kill_cnt_q, kill_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;

    logic [31:0] inst_mem_q [FIFO_DEPTH];
    logic [31:0] addr_mem_q [FIFO_DEPTH];
    logic [31:0] aq_mem_q   [FIFO_DEPTH];

    logic        issue, push, pop, kill;
    logic [CW:0] credit_used;

    always_comb begin
        inst_valid_o = (count_q != '0);
        inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : NOP_INST;
        inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : 32'h0;
        imem_addr_o  = pc_q;
    end

    // Credit counts the slot freed by this cycle's pop so a full-rate stream never bubbles.
    always_comb begin
        pop         = inst_valid_o && !hold_i;
        credit_used = {1'b0, outstanding_q} + {1'b0, count_q} - (CW + 1)'(pop);
        imem_req_o  = !rst && !jump_en_i && (credit_used < DEPTH_W);
        issue       = imem_req_o && imem_gnt_i;
        kill        = (kill_cnt_q != '0);
        push        = imem_rvalid_i && !kill && !jump_en_i;
    end

    always_comb begin
        pc_d          = pc_q;
        kill_cnt_d    = kill_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        aq_wr_d       = aq_wr_q;
        aq_rd_d       = aq_rd_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid_i);
        count_d       = count_q + CW'(push) - CW'(pop);

        if (issue) begin
            pc_d    = pc_q + 32'd4;
            aq_wr_d = aq_wr_q + PW'(1);
        end
        // Killed responses still consume their address-queue entry to keep it in order.
        if (imem_rvalid_i) begin
            aq_rd_d = aq_rd_q + PW'(1);
            if (kill) begin
                kill_cnt_d = kill_cnt_q - CW'(1);
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (jump_en_i) begin
            pc_d       = {jump_addr_i[31:2], 2'b00};
            kill_cnt_d = outstanding_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_ADDR;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            aq_wr_q       <= '0;
            aq_rd_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            aq_wr_q       <= aq_wr_d;
            aq_rd_q       <= aq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            aq_mem_q[aq_wr_q] <= pc_q;
        end
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata_i;
            addr_mem_q[wr_ptr_q] <= aq_mem_q[aq_rd_q];
        end
    end

    assert property (@(posedge clk) disable iff (rst) imem_rvalid_i |-> (outstanding_q != '0));
    assert property (@(posedge clk) disable iff (rst) (push && (count_q == FULL)) |-> pop);

endmodule
